// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read sequencer: FSM state
// encoding and the flash opcodes / filler byte driven onto the shift engine.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        IDLE    = 3'd1,
        ISSUE   = 3'd2,
        GAP     = 3'd3,
        WAIT    = 3'd4,
        DELIVER = 3'd5,
        FINISH  = 3'd6
    } flash_state_t;

    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_FASTREAD = 8'h0B;
    localparam logic [7:0] DUMMY_BYTE  = 8'h00;

endpackage

// File: rtl/spi_flash_reader.sv
// SPI flash array reader: sends opcode + 24-bit address through the byte shift
// engine, then streams len read bytes out on a valid/ready port.
// Optional fast read (opcode 0x0B + one dummy byte) via SPI_FLASH_FASTREAD_EN.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int         ADDR_W = 24,
    parameter int         LEN_W  = 16,
    parameter logic [7:0] RD_OP  = OP_READ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              eng_we,
    output logic [7:0]        eng_di,
    input  logic [7:0]        eng_do,
    input  logic              eng_ready,
    output logic              eng_ss_reset
);

`ifdef SPI_FLASH_FASTREAD_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    localparam logic [7:0]       OPCODE  = FAST_EN ? OP_FASTREAD : RD_OP;
    localparam logic [2:0]       HDR_N   = FAST_EN ? 3'd5 : 3'd4;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    flash_state_t      state_r,        state_nxt_s;
    logic [ADDR_W-1:0] addr_r,         addr_nxt_s;
    logic [LEN_W-1:0]  remaining_r,    remaining_nxt_s;
    logic [2:0]        hdr_idx_r,      hdr_idx_nxt_s;
    logic              busy_r,         busy_nxt_s;
    logic              done_r,         done_nxt_s;
    logic [7:0]        rd_data_r,      rd_data_nxt_s;
    logic              rd_valid_r,     rd_valid_nxt_s;
    logic              eng_we_r,       eng_we_nxt_s;
    logic [7:0]        eng_di_r,       eng_di_nxt_s;
    logic              eng_ss_reset_r, eng_ss_reset_nxt_s;
    logic [7:0]        cur_byte_s;
    logic              in_header_s;

    assign in_header_s = (hdr_idx_r < HDR_N);

    // Byte to transmit next: header bytes by index; dummy and data phase both send 0x00
    always_comb begin
        cur_byte_s = DUMMY_BYTE;
        case (hdr_idx_r)
            3'd0:    cur_byte_s = OPCODE;
            3'd1:    cur_byte_s = addr_r[ADDR_W-1 -: 8];
            3'd2:    cur_byte_s = addr_r[ADDR_W-9 -: 8];
            3'd3:    cur_byte_s = addr_r[ADDR_W-17 -: 8];
            default: cur_byte_s = DUMMY_BYTE;
        endcase
    end

    // Next-state and next-register values; every output is registered below
    always_comb begin
        state_nxt_s        = state_r;
        addr_nxt_s         = addr_r;
        remaining_nxt_s    = remaining_r;
        hdr_idx_nxt_s      = hdr_idx_r;
        busy_nxt_s         = busy_r;
        done_nxt_s         = 1'b0;
        rd_data_nxt_s      = rd_data_r;
        rd_valid_nxt_s     = rd_valid_r;
        eng_we_nxt_s       = 1'b0;
        eng_di_nxt_s       = eng_di_r;
        eng_ss_reset_nxt_s = 1'b0;

        case (state_r)
            BOOT: begin
                if (eng_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BOOT;
                end
            end
            IDLE: begin
                if (start) begin
                    addr_nxt_s      = addr;
                    remaining_nxt_s = len;
                    hdr_idx_nxt_s   = 3'd0;
                    busy_nxt_s      = 1'b1;
                    if (len == {LEN_W{1'b0}}) begin
                        state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                eng_we_nxt_s = 1'b1;
                eng_di_nxt_s = cur_byte_s;
                state_nxt_s  = GAP;
            end
            // The engine drops ready one cycle after the load strobe, so skip a cycle
            GAP: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (!eng_ready) begin
                    state_nxt_s = WAIT;
                end else if (in_header_s) begin
                    hdr_idx_nxt_s = hdr_idx_r + 3'd1;
                    state_nxt_s   = ISSUE;
                end else begin
                    rd_data_nxt_s  = eng_do;
                    rd_valid_nxt_s = 1'b1;
                    state_nxt_s    = DELIVER;
                end
            end
            DELIVER: begin
                if (rd_valid_r && rd_ready) begin
                    rd_valid_nxt_s  = 1'b0;
                    remaining_nxt_s = remaining_r - LEN_ONE;
                    if (remaining_r == LEN_ONE) begin
                        state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end else begin
                    state_nxt_s = DELIVER;
                end
            end
            FINISH: begin
                eng_ss_reset_nxt_s = 1'b1;
                done_nxt_s         = 1'b1;
                busy_nxt_s         = 1'b0;
                state_nxt_s        = IDLE;
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r         <= {ADDR_W{1'b0}};
            remaining_r    <= {LEN_W{1'b0}};
            hdr_idx_r      <= 3'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            rd_data_r      <= 8'h00;
            rd_valid_r     <= 1'b0;
            eng_we_r       <= 1'b0;
            eng_di_r       <= 8'h00;
            eng_ss_reset_r <= 1'b0;
        end else begin
            addr_r         <= addr_nxt_s;
            remaining_r    <= remaining_nxt_s;
            hdr_idx_r      <= hdr_idx_nxt_s;
            busy_r         <= busy_nxt_s;
            done_r         <= done_nxt_s;
            rd_data_r      <= rd_data_nxt_s;
            rd_valid_r     <= rd_valid_nxt_s;
            eng_we_r       <= eng_we_nxt_s;
            eng_di_r       <= eng_di_nxt_s;
            eng_ss_reset_r <= eng_ss_reset_nxt_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign rd_data      = rd_data_r;
    assign rd_valid     = rd_valid_r;
    assign eng_we       = eng_we_r;
    assign eng_di       = eng_di_r;
    assign eng_ss_reset = eng_ss_reset_r;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader with a behavioural shift engine that
// returns bytes from a random script; honours SPI_FLASH_FASTREAD_EN.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FASTREAD_EN
    localparam int         HDR = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic        clk, rst, start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        busy, done, rd_valid, rd_ready;
    logic [7:0]  rd_data, eng_di, eng_do;
    logic        eng_we, eng_ready, eng_ss_reset;

    int          n_cmp = 0, n_bad = 0;
    logic [7:0]  script [1024];
    logic [7:0]  di_q [$];
    logic [7:0]  rd_q [$];
    int          next_load = 0, done_seen = 0, done_exp = 0, rd_acc = 0;
    bit          hold_rdy = 1'b0, rand_rdy = 1'b0;

    spi_flash_reader dut (
        .clk(clk), .reset(rst), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .eng_we(eng_we), .eng_di(eng_di), .eng_do(eng_do),
        .eng_ready(eng_ready), .eng_ss_reset(eng_ss_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural engine: wakes 20 cycles after reset, ready low 9 cycles per load
    int         boot_cnt, sh_cnt, load_idx;
    bit         booted;
    logic [7:0] pending;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_ready <= 1'b0; eng_do <= 8'h00; boot_cnt <= 0; sh_cnt <= 0;
            load_idx <= 0; booted <= 1'b0; pending <= 8'h00;
        end else if (!booted) begin
            boot_cnt <= boot_cnt + 1;
            if (boot_cnt == 19) begin
                eng_ready <= 1'b1;
                booted    <= 1'b1;
            end
        end else if (eng_we) begin
            eng_ready <= 1'b0;
            sh_cnt    <= 9;
            pending   <= script[load_idx % 1024];
            load_idx  <= load_idx + 1;
        end else if (sh_cnt != 0) begin
            sh_cnt <= sh_cnt - 1;
            if (sh_cnt == 1) begin
                eng_ready <= 1'b1;
                eng_do    <= pending;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer ready driver
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            rd_ready = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a load or a read byte
    initial begin
        logic       pv, pr;
        logic [7:0] pd;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (eng_we) begin
                    chk("eng_we_expected", 32'(di_q.size() != 0), 32'd1);
                    if (di_q.size() != 0) chk("eng_di", 32'(eng_di), 32'(di_q.pop_front()));
                end
                if (rd_valid && rd_ready) begin
                    chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
                    if (rd_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
                    rd_acc++;
                end
                if (pv && !pr) begin
                    chk("rd_valid_hold", 32'(rd_valid), 32'd1);
                    chk("rd_data_hold", 32'(rd_data), 32'(pd));
                end
                if (done || eng_ss_reset) chk("ss_reset_with_done", 32'(eng_ss_reset), 32'(done));
                if (done) begin
                    done_seen++;
                    chk("busy_low_at_done", 32'(busy), 32'd0);
                end
                pv = rd_valid; pr = rd_ready; pd = rd_data;
            end
        end
    end

    // Reference model: the SPI traffic and read bytes one read command must produce
    task automatic expect_xfer(input logic [23:0] a, input int l);
        logic [7:0] hb [5];
        hb[0] = OPC; hb[1] = a[23:16]; hb[2] = a[15:8]; hb[3] = a[7:0]; hb[4] = 8'h00;
        if (l > 0) begin
            for (int i = 0; i < HDR; i++) di_q.push_back(hb[i]);
            for (int i = 0; i < l; i++) begin
                di_q.push_back(8'h00);
                rd_q.push_back(script[(next_load + HDR + i) % 1024]);
            end
            next_load += HDR + l;
        end
        done_exp++;
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] l);
        @(posedge clk); #2;
        start = 1'b1; addr = a; len = l;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int s, k;
        s = done_seen; k = 0;
        while (done_seen == s && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        chk("done_within_budget", 32'(done_seen != s), 32'd1);
        chk("di_queue_drained", 32'(di_q.size()), 32'd0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    endtask

    task automatic do_xfer(input logic [23:0] a, input int l);
        expect_xfer(a, l);
        pulse_start(a, 16'(l));
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done(300 + l * 150);
    endtask

    task automatic wait_boot();
        int k;
        k = 0;
        while (!eng_ready && k < 100) begin
            @(posedge clk); #2;
            k++;
        end
        chk("engine_woke", 32'(eng_ready), 32'd1);
        @(posedge clk); #2;
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_eng_we", 32'(eng_we), 32'd0);
        chk("rst_eng_di", 32'(eng_di), 32'd0);
        chk("rst_ss_reset", 32'(eng_ss_reset), 32'd0);
    endtask

    initial begin
        int we_cnt, k, s;
        rst = 1'b1; start = 1'b0; addr = 24'h0; len = 16'h0;
        for (int i = 0; i < 1024; i++) script[i] = 8'($urandom_range(0, 255));
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // start during engine wake-up is ignored
        pulse_start(24'h777777, 16'd3);
        chk("boot_start_ignored", 32'(busy), 32'd0);
        wait_boot();
        chk("idle_not_busy", 32'(busy), 32'd0);

        do_xfer(24'h012345, 2);

        // consumer stalls the first data byte for 30 cycles
        hold_rdy = 1'b1;
        expect_xfer(24'h00A5F0, 3);
        pulse_start(24'h00A5F0, 16'd3);
        k = 0;
        while (!rd_valid && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        chk("first_byte_valid", 32'(rd_valid), 32'd1);
        we_cnt = 0;
        repeat (30) begin
            @(posedge clk); #2;
            we_cnt += int'(eng_we);
        end
        chk("no_issue_while_stalled", 32'(we_cnt), 32'd0);
        hold_rdy = 1'b0;
        wait_done(600);

        // zero-length request: done and chip-select release two cycles after start
        expect_xfer(24'h555555, 0);
        @(posedge clk); #2;
        start = 1'b1; addr = 24'h555555; len = 16'd0;
        @(posedge clk); #2;
        start = 1'b0;
        chk("len0_busy", 32'(busy), 32'd1);
        chk("len0_done_early", 32'(done), 32'd0);
        @(posedge clk); #2;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_ss_reset", 32'(eng_ss_reset), 32'd1);
        chk("len0_busy_low", 32'(busy), 32'd0);
        @(posedge clk); #2;
        chk("len0_done_pulse", 32'(done), 32'd0);
        chk("len0_ss_pulse", 32'(eng_ss_reset), 32'd0);

        // start while busy is ignored
        expect_xfer(24'h102030, 3);
        pulse_start(24'h102030, 16'd3);
        repeat (20) @(posedge clk);
        pulse_start(24'hABCDEF, 16'd7);
        chk("busy_during_ignored_start", 32'(busy), 32'd1);
        wait_done(800);

        // randomized transfers with random consumer backpressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 12; t++) do_xfer(24'($urandom), int'($urandom_range(0, 5)));
        rand_rdy = 1'b0;

        // reset asserted during the data phase
        expect_xfer(24'h0F0F0F, 4);
        pulse_start(24'h0F0F0F, 16'd4);
        s = rd_acc; k = 0;
        while (rd_acc == s && k < 300) begin
            @(posedge clk); #2;
            k++;
        end
        chk("mid_byte_accepted", 32'(rd_acc != s), 32'd1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals();
        di_q.delete(); rd_q.delete(); next_load = 0; done_exp--;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        pulse_start(24'h123456, 16'd1);
        chk("back_in_boot", 32'(busy), 32'd0);
        wait_boot();
        do_xfer(24'hFEDCBA, 2);

        repeat (5) @(posedge clk);
        chk("done_count", 32'(done_seen), 32'(done_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
